// File: rtl/cyq_seq_det_pkg.sv
// Shared defaults and elaboration-time helpers for the serial sequence detector.
// The next-state function builds the KMP transition table from PATTERN.
package cyq_fsm_pkg;

    localparam int               DEF_LEN     = 3;
    localparam logic [DEF_LEN-1:0] DEF_PATTERN = 3'b011;
    localparam int               DEF_CNT_W   = 8;

    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest prefix of pattern that is a suffix of (first s pattern bits, then x).
    // hist[0] holds the newest bit; hist[s] holds the oldest.
    function automatic int next_s(input logic [7:0] pattern, input int len,
                                  input int s, input logic x);
        logic [8:0] hist;
        logic       ok;
        int         best;
        hist = 9'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < s) begin
                hist[4'(s - i)] = pattern[3'(len - 1 - i)];
            end
        end
        hist[0] = x;
        best = 0;
        for (int k = 1; k <= 8; k++) begin
            if ((k <= len) && (k <= s + 1)) begin
                ok = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    if (j < k) begin
                        if (hist[4'(k - 1 - j)] != pattern[3'(len - 1 - j)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/cyq_seq_det_if.sv
// Sample/clear inputs and match/count outputs of the sequence detector.
interface cyq_seq_det_if
    import cyq_fsm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             En;
    logic             X;
    logic             Clr;
    logic             Y;
    logic [CNT_W-1:0] Count;

    modport master (output En, output X, output Clr, input Y, input Count);
    modport slave  (input En, input X, input Clr, output Y, output Count);
endinterface

// File: rtl/cyq_seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment loads 1 so the coincident event is not lost.
module cyq_sat_cnt #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Inc,
    input  logic         Clr,
    output logic [W-1:0] Q
);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_q;

    // Count register: clear has priority, increment stops at all-ones.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_q <= '0;
        end else if (Clr) begin
            r_q <= Inc ? W'(1) : '0;
        end else if (Inc && (r_q != MAX)) begin
            r_q <= r_q + W'(1);
        end else begin
            r_q <= r_q;
        end
    end

    assign Q = r_q;
endmodule

// File: rtl/cyq_seq_det.sv
// Moore serial pattern detector with KMP transitions and optional match counter.
// Counter is built only when CYQ_SEQ_DET_CNT_EN is defined; otherwise Count is 0.
module cyq_seq_det
    import cyq_fsm_pkg::*;
#(
    parameter int             LEN     = DEF_LEN,
    parameter logic [LEN-1:0] PATTERN = LEN'(DEF_PATTERN),
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = DEF_CNT_W
) (
    input logic          Clk,
    input logic          Rst,
    cyq_seq_det_if.slave bus
);
    localparam int SW = state_w(LEN);
    localparam int NT = 2 ** (SW + 1);

    logic [SW-1:0]    w_next_tab [NT];
    logic [SW-1:0]    r_s;
    logic [SW-1:0]    w_next_s;
    logic             r_y;
    logic             w_hit;
    logic             w_inc;
    logic [CNT_W-1:0] w_count;

    // Table indexed by {state, bit}; non-overlapping mode reuses the idle row from MATCH.
    for (genvar gi = 0; gi < NT; gi++) begin : g_tab
        localparam int GS = gi / 2;
        localparam int GX = gi % 2;
        if (GS <= LEN) begin : g_live
            assign w_next_tab[gi] = SW'(next_s(8'(PATTERN), LEN,
                                               ((GS == LEN) && (OVERLAP == 0)) ? 0 : GS,
                                               1'(GX)));
        end else begin : g_dead
            assign w_next_tab[gi] = '0;
        end
    end

    // Next-state lookup and match-entry detect for this sample.
    always_comb begin
        w_next_s = w_next_tab[{r_s, bus.X}];
        w_hit    = (w_next_s == SW'(LEN));
        w_inc    = bus.En & w_hit;
    end

    // Detector state and registered Moore flag; both hold on idle cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s <= '0;
            r_y <= 1'b0;
        end else if (bus.En) begin
            r_s <= w_next_s;
            r_y <= w_hit;
        end else begin
            r_s <= r_s;
            r_y <= r_y;
        end
    end

`ifdef CYQ_SEQ_DET_CNT_EN
    cyq_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .Clk(Clk),
        .Rst(Rst),
        .Inc(w_inc),
        .Clr(bus.Clr),
        .Q  (w_count)
    );
`else
    logic w_unused;
    assign w_unused = w_inc ^ bus.Clr;
    assign w_count  = '0;
`endif

    assign bus.Y     = r_y;
    assign bus.Count = w_count;
endmodule

// File: tb/tb_cyq_seq_det.sv
// Scoreboard bench for cyq_seq_det: four parameterisations driven by directed
// vectors; a monitor pops hand-computed expectations after each sampling edge.
module tb_cyq_seq_det;
    import cyq_fsm_pkg::*;

`ifdef CYQ_SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    cyq_seq_det_if #(.CNT_W(8)) if0 ();
    cyq_seq_det_if #(.CNT_W(8)) if1 ();
    cyq_seq_det_if #(.CNT_W(8)) if2 ();
    cyq_seq_det_if #(.CNT_W(2)) if3 ();

    cyq_seq_det u0 (.Clk(Clk), .Rst(Rst), .bus(if0));
    cyq_seq_det #(.PATTERN(3'b101), .OVERLAP(1)) u1 (.Clk(Clk), .Rst(Rst), .bus(if1));
    cyq_seq_det #(.PATTERN(3'b101), .OVERLAP(0)) u2 (.Clk(Clk), .Rst(Rst), .bus(if2));
    cyq_seq_det #(.CNT_W(2)) u3 (.Clk(Clk), .Rst(Rst), .bus(if3));

    typedef struct {
        int    dut;
        logic  y;
        int    cnt;
        string nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    int xs_a[7] = '{0, 1, 1, 1, 0, 1, 1};
    int ys_a[7] = '{0, 0, 1, 0, 0, 0, 1};
    int cs_a[7] = '{0, 0, 1, 1, 1, 1, 2};
    int xs_b[5] = '{1, 0, 1, 0, 1};
    int ys_b[5] = '{0, 0, 1, 0, 1};
    int cs_b[5] = '{0, 0, 1, 1, 2};
    int ys_c[5] = '{0, 0, 1, 0, 0};
    int cs_c[5] = '{0, 0, 1, 1, 1};

    function automatic int act_y(input int d);
        case (d)
            0:       return int'(if0.Y);
            1:       return int'(if1.Y);
            2:       return int'(if2.Y);
            3:       return int'(if3.Y);
            default: return -1;
        endcase
    endfunction

    function automatic int act_cnt(input int d);
        case (d)
            0:       return int'(if0.Count);
            1:       return int'(if1.Count);
            2:       return int'(if2.Count);
            3:       return int'(if3.Count);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        if0.En = 1'b0; if0.X = 1'b0; if0.Clr = 1'b0;
        if1.En = 1'b0; if1.X = 1'b0; if1.Clr = 1'b0;
        if2.En = 1'b0; if2.X = 1'b0; if2.Clr = 1'b0;
        if3.En = 1'b0; if3.X = 1'b0; if3.Clr = 1'b0;
    endtask

    // One cycle of stimulus on one DUT; expected outputs after the next rising edge.
    task automatic step(input int dut, input logic en, input logic x, input logic clr,
                        input logic ey, input int ec, input string nm);
        exp_t e;
        @(negedge Clk);
        drive_idle();
        case (dut)
            0:       begin if0.En = en; if0.X = x; if0.Clr = clr; end
            1:       begin if1.En = en; if1.X = x; if1.Clr = clr; end
            2:       begin if2.En = en; if2.X = x; if2.Clr = clr; end
            3:       begin if3.En = en; if3.X = x; if3.Clr = clr; end
            default: ;
        endcase
        e.dut = dut;
        e.y   = ey;
        e.cnt = CNT_ON ? ec : 0;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        drive_idle();
        Rst = 1'b1;
        @(negedge Clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset.y[%0d]", d), act_y(d), 0);
            check($sformatf("reset.cnt[%0d]", d), act_cnt(d), 0);
        end
        Rst = 1'b0;
    endtask

    // Reset pulse placed between clock edges; outputs must clear before any edge.
    task automatic rst_pulse(input string nm);
        @(posedge Clk);
        #3;
        drive_idle();
        Rst = 1'b1;
        #1;
        check({nm, ".y"}, act_y(0), 0);
        check({nm, ".cnt"}, act_cnt(0), 0);
        Rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.nm, ".y"}, act_y(e.dut), int'(e.y));
                check({e.nm, ".cnt"}, act_cnt(e.dut), e.cnt);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        Rst = 1'b1;
        drive_idle();
        #1;

        do_reset();
        for (int i = 0; i < 7; i++)
            step(0, 1'b1, 1'(xs_a[i]), 1'b0, 1'(ys_a[i]), cs_a[i], $sformatf("ovl011[%0d]", i));

        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, 1'b1, 1'(xs_b[i]), 1'b0, 1'(ys_b[i]), cs_b[i], $sformatf("ovl101[%0d]", i));

        do_reset();
        for (int i = 0; i < 5; i++)
            step(2, 1'b1, 1'(xs_b[i]), 1'b0, 1'(ys_c[i]), cs_c[i], $sformatf("novl101[%0d]", i));

        do_reset();
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "pre_rst0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "pre_rst1");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1, "pre_rst2");
        rst_pulse("rst_on_match");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "mid_rst0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "mid_rst1");
        rst_pulse("rst_mid_pat");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "post_rst");

        do_reset();
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "hold_in0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "hold_in1");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1, "hold_in2");
        for (int i = 0; i < 4; i++)
            step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1, $sformatf("hold[%0d]", i));
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1, "m2_0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1, "m2_1");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 2, "m2_2");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 2, "m3_0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 2, "m3_1");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 1, "clr_inc");
        step(0, 1'b0, 1'b0, 1'b1, 1'b1, 0, "clr_idle");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "after_clr0");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "after_clr1");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "after_clr2");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "after_clr3");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1, "after_clr4");
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "clr_noinc");

        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(3, 1'b1, 1'b0, 1'b0, 1'b0, (k < 3) ? k : 3, $sformatf("sat%0d_0", k));
            step(3, 1'b1, 1'b1, 1'b0, 1'b0, (k < 3) ? k : 3, $sformatf("sat%0d_1", k));
            step(3, 1'b1, 1'b1, 1'b0, 1'b1, (k + 1 < 3) ? k + 1 : 3, $sformatf("sat%0d_2", k));
        end
        step(3, 1'b0, 1'b0, 1'b1, 1'b1, 0, "sat_clr");

        @(negedge Clk);
        drive_idle();
        repeat (3) @(negedge Clk);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
